// File: rtl/midi_voice_allocator_if.sv
// Byte-in / voice-out bundle for midi_voice_allocator.
// The master side feeds UART bytes and watches the voice bank; the slave side is the allocator.
interface midi_voice_allocator_if #(
    parameter int VOICES = 4
);
    logic [7:0]          byteInput;
    logic                byteReady;
    logic [7*VOICES-1:0] voiceNote;
    logic [7*VOICES-1:0] voiceVelocity;
    logic [VOICES-1:0]   voiceGate;
    logic [VOICES-1:0]   voiceUpdate;

    modport master (
        output byteInput, byteReady,
        input  voiceNote, voiceVelocity, voiceGate, voiceUpdate
    );

    modport slave (
        input  byteInput, byteReady,
        output voiceNote, voiceVelocity, voiceGate, voiceUpdate
    );
endinterface

// File: rtl/midi_voice_allocator.sv
// MIDI note/CC parser feeding a fixed voice pool: retrigger, free allocation, round-robin steal.
// Optional running status is enabled by defining MIDI_RUNNING_STATUS_EN.
module midi_voice_allocator #(
    parameter int VOICES  = 4,
    parameter int CHANNEL = 0
) (
    input  logic                   clock,
    input  logic                   resetN,
    midi_voice_allocator_if.slave  bus
);
    localparam int PW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [3:0] CH = 4'(CHANNEL);

    typedef enum logic [1:0] {S_IDLE, S_DATA1, S_DATA2, S_SKIP} state_t;
    typedef enum logic [1:0] {K_OFF, K_ON, K_CC}               kind_t;
    typedef enum logic [1:0] {C_NONE, C_ON, C_OFF, C_ALL}      cmd_t;

    state_t        r_state;
    kind_t         r_kind;
    cmd_t          r_cmd_type;
    logic          r_ready_prev;
    logic [6:0]    r_d1;
    logic [6:0]    r_cmd_note;
    logic [6:0]    r_cmd_vel;
`ifdef MIDI_RUNNING_STATUS_EN
    logic          r_status_valid;
`endif

    logic [6:0]        r_note [VOICES];
    logic [6:0]        r_vel  [VOICES];
    logic [VOICES-1:0] r_gate;
    logic [VOICES-1:0] r_update;
    logic [PW-1:0]     r_steal_ptr;

    logic              w_new_byte;
    logic [VOICES-1:0] w_match;
    logic              w_retrig_any;
    logic [PW-1:0]     w_retrig_idx;
    logic              w_free_any;
    logic [PW-1:0]     w_free_idx;

    assign w_new_byte = bus.byteReady & ~r_ready_prev;

    // Parser: one byte per rising edge of byteReady; a finished message becomes a one-cycle command.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state        <= S_IDLE;
            r_kind         <= K_OFF;
            r_cmd_type     <= C_NONE;
            r_ready_prev   <= 1'b1;
            r_d1           <= '0;
            r_cmd_note     <= '0;
            r_cmd_vel      <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
            r_status_valid <= 1'b0;
`endif
        end else begin
            r_ready_prev <= bus.byteReady;
            r_cmd_type   <= C_NONE;
            if (w_new_byte && bus.byteInput < 8'hF8) begin
                if (bus.byteInput[7]) begin
                    if (bus.byteInput == {4'h8, CH} || bus.byteInput == {4'h9, CH} ||
                        bus.byteInput == {4'hB, CH}) begin
                        r_kind  <= (bus.byteInput[5:4] == 2'b00) ? K_OFF :
                                   (bus.byteInput[5:4] == 2'b01) ? K_ON : K_CC;
                        r_state <= S_DATA1;
`ifdef MIDI_RUNNING_STATUS_EN
                        r_status_valid <= 1'b1;
`endif
                    end else begin
                        r_state <= S_SKIP;
`ifdef MIDI_RUNNING_STATUS_EN
                        r_status_valid <= 1'b0;
`endif
                    end
                end else begin
                    case (r_state)
                        S_DATA1: begin
                            r_d1    <= bus.byteInput[6:0];
                            r_state <= S_DATA2;
                        end
                        S_DATA2: begin
                            r_state    <= S_IDLE;
                            r_cmd_note <= r_d1;
                            r_cmd_vel  <= bus.byteInput[6:0];
                            case (r_kind)
                                K_ON:    r_cmd_type <= (bus.byteInput[6:0] == 7'd0) ? C_OFF : C_ON;
                                K_OFF:   r_cmd_type <= C_OFF;
                                default: r_cmd_type <= (r_d1 == 7'd123) ? C_ALL : C_NONE;
                            endcase
                        end
`ifdef MIDI_RUNNING_STATUS_EN
                        S_IDLE: begin
                            if (r_status_valid) begin
                                r_d1    <= bus.byteInput[6:0];
                                r_state <= S_DATA2;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
            assign w_match[gi] = r_gate[gi] && (r_note[gi] == r_cmd_note);
            assign bus.voiceNote[7*gi +: 7]     = r_note[gi];
            assign bus.voiceVelocity[7*gi +: 7] = r_vel[gi];
        end
    endgenerate

    // Scanning downwards leaves the lowest qualifying index in each encoder.
    always_comb begin
        w_retrig_any = 1'b0;
        w_retrig_idx = '0;
        w_free_any   = 1'b0;
        w_free_idx   = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_retrig_any = 1'b1;
                w_retrig_idx = PW'(i);
            end
            if (!r_gate[i]) begin
                w_free_any = 1'b1;
                w_free_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < VOICES; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
            end
            r_gate      <= '0;
            r_update    <= '0;
            r_steal_ptr <= '0;
        end else begin
            r_update <= '0;
            case (r_cmd_type)
                C_ON: begin
                    if (w_retrig_any) begin
                        r_vel[w_retrig_idx]    <= r_cmd_vel;
                        r_update[w_retrig_idx] <= 1'b1;
                    end else if (w_free_any) begin
                        r_note[w_free_idx]   <= r_cmd_note;
                        r_vel[w_free_idx]    <= r_cmd_vel;
                        r_gate[w_free_idx]   <= 1'b1;
                        r_update[w_free_idx] <= 1'b1;
                    end else begin
                        r_note[r_steal_ptr]   <= r_cmd_note;
                        r_vel[r_steal_ptr]    <= r_cmd_vel;
                        r_gate[r_steal_ptr]   <= 1'b1;
                        r_update[r_steal_ptr] <= 1'b1;
                        r_steal_ptr <= (r_steal_ptr == PW'(VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
                    end
                end
                C_OFF: begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (w_match[i]) begin
                            r_gate[i]   <= 1'b0;
                            r_update[i] <= 1'b1;
                        end
                    end
                end
                C_ALL: begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (r_gate[i]) begin
                            r_gate[i]   <= 1'b0;
                            r_update[i] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.voiceGate   = r_gate;
    assign bus.voiceUpdate = r_update;
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator (VOICES=4, CHANNEL=0), one line per transaction.
module tb_midi_voice_allocator;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    midi_voice_allocator_if #(.VOICES(4)) bus ();

    midi_voice_allocator #(.VOICES(4), .CHANNEL(0)) dut (
        .clock  (clk),
        .resetN (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] pack4(input logic [6:0] v0, v1, v2, v3);
        return {v3, v2, v1, v0};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.byteInput = b;
        bus.byteReady = 1'b1;
        @(negedge clk);
        bus.byteReady = 1'b0;
    endtask

    task automatic msg3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        $display("tx %02h %02h %02h", a, b, c);
        send(a);
        send(b);
        send(c);
    endtask

    // Called right after the final byte: no change yet, then the pulse, then it clears.
    task automatic expect_pulse(input string tag, input logic [3:0] exp);
        check_val({tag, "_lat"}, 32'(bus.voiceUpdate), 32'h0);
        @(negedge clk);
        check_val({tag, "_upd"}, 32'(bus.voiceUpdate), 32'(exp));
        @(negedge clk);
        check_val({tag, "_clr"}, 32'(bus.voiceUpdate), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.byteInput = 8'h90;
        bus.byteReady = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_gate", 32'(bus.voiceGate), 32'h0);
        check_val("rst_note", 32'(bus.voiceNote), 32'h0);
        check_val("rst_vel",  32'(bus.voiceVelocity), 32'h0);
        check_val("rst_upd",  32'(bus.voiceUpdate), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.byteReady = 1'b0;
        $display("tx held-ready 90 then 3C 64");
        send(8'h3C);
        send(8'h64);
        expect_pulse("held", 4'h0);
        check_val("held_gate", 32'(bus.voiceGate), 32'h0);

        msg3(8'h90, 8'h3C, 8'h64);
        expect_pulse("on60", 4'h1);
        check_val("on60_gate", 32'(bus.voiceGate), 32'h1);
        check_val("on60_note", 32'(bus.voiceNote[6:0]), 32'd60);
        check_val("on60_vel",  32'(bus.voiceVelocity[6:0]), 32'd100);

        msg3(8'h80, 8'h3C, 8'h00);
        expect_pulse("off60", 4'h1);
        check_val("off60_gate", 32'(bus.voiceGate), 32'h0);
        check_val("off60_note", 32'(bus.voiceNote[6:0]), 32'd60);
        msg3(8'h80, 8'h3C, 8'h00);
        expect_pulse("off60_rep", 4'h0);

        msg3(8'h90, 8'd60, 8'h64); expect_pulse("fill60", 4'h1);
        msg3(8'h90, 8'd62, 8'h64); expect_pulse("fill62", 4'h2);
        msg3(8'h90, 8'd64, 8'h64); expect_pulse("fill64", 4'h4);
        msg3(8'h90, 8'd65, 8'h64); expect_pulse("fill65", 4'h8);
        check_val("fill_gate", 32'(bus.voiceGate), 32'hF);
        msg3(8'h90, 8'd67, 8'h64); expect_pulse("steal67", 4'h1);
        msg3(8'h90, 8'd69, 8'h64); expect_pulse("steal69", 4'h2);
        msg3(8'h90, 8'd64, 8'h20); expect_pulse("retrig64", 4'h4);
        check_val("retrig_vel", 32'(bus.voiceVelocity[20:14]), 32'd32);
        msg3(8'h90, 8'd71, 8'h64); expect_pulse("steal71", 4'h4);
        check_val("steal_notes", 32'(bus.voiceNote), 32'(pack4(7'd67, 7'd69, 7'd71, 7'd65)));
        check_val("steal_vel2", 32'(bus.voiceVelocity[20:14]), 32'd100);

        msg3(8'hB0, 8'h7B, 8'h00); expect_pulse("alloff", 4'hF);
        check_val("alloff_gate", 32'(bus.voiceGate), 32'h0);
        msg3(8'hB0, 8'h7B, 8'h00); expect_pulse("alloff_rep", 4'h0);
        msg3(8'h91, 8'h3C, 8'h64); expect_pulse("otherch", 4'h0);
        check_val("otherch_gate", 32'(bus.voiceGate), 32'h0);
        msg3(8'hB0, 8'h07, 8'h40); expect_pulse("cc7", 4'h0);

        $display("tx 90 3C F8 50");
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h50);
        expect_pulse("rt", 4'h1);
        check_val("rt_note", 32'(bus.voiceNote[6:0]), 32'd60);
        check_val("rt_vel",  32'(bus.voiceVelocity[6:0]), 32'd80);

        $display("tx 90 3E 80 3E 00");
        send(8'h90); send(8'h3E); send(8'h80); send(8'h3E); send(8'h00);
        expect_pulse("abort", 4'h0);
        check_val("abort_gate", 32'(bus.voiceGate), 32'h1);

        msg3(8'h90, 8'h40, 8'h64); expect_pulse("rs_first", 4'h2);
        $display("tx 41 64 (running status)");
        send(8'h41); send(8'h64);
`ifdef MIDI_RUNNING_STATUS_EN
        expect_pulse("rs_on", 4'h4);
        check_val("rs_on_gate", 32'(bus.voiceGate), 32'h7);
`else
        expect_pulse("rs_on", 4'h0);
        check_val("rs_on_gate", 32'(bus.voiceGate), 32'h3);
`endif
        $display("tx 40 00 (running status)");
        send(8'h40); send(8'h00);
`ifdef MIDI_RUNNING_STATUS_EN
        expect_pulse("rs_off", 4'h2);
        check_val("rs_off_gate", 32'(bus.voiceGate), 32'h5);
`else
        expect_pulse("rs_off", 4'h0);
        check_val("rs_off_gate", 32'(bus.voiceGate), 32'h3);
`endif

        $display("tx 90 45 then async reset");
        send(8'h90); send(8'h45);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_gate", 32'(bus.voiceGate), 32'h0);
        check_val("arst_note", 32'(bus.voiceNote), 32'h0);
        check_val("arst_vel",  32'(bus.voiceVelocity), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h45); send(8'h64);
        expect_pulse("post_rst", 4'h0);
        check_val("post_rst_gate", 32'(bus.voiceGate), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
